// File: rtl/inta_cycle_sequencer_if.sv
// Pin bundle between the interrupt controller, the acknowledge
// sequencer and the core's interrupt entry logic.
interface inta_if;
  logic       INT;
  logic       int_enable;
  logic [7:0] D_in;
  logic       INTA_n;
  logic       bus_hold;
  logic       vec_valid;
  logic [7:0] vec_data;
  logic       vec_ready;
  logic       busy;

  modport master (
    input  INT, int_enable, D_in, vec_ready,
    output INTA_n, bus_hold, vec_valid, vec_data, busy
  );

  modport slave (
    output INT, int_enable, D_in, vec_ready,
    input  INTA_n, bus_hold, vec_valid, vec_data, busy
  );
endinterface

// File: rtl/inta_cycle_sequencer.sv
// Two-pulse INTA_n acknowledge sequencer (8086 mode).
// Captures the vector on pulse 2 and hands it to the core.
module inta_cycle_sequencer #(
  parameter int PULSE_W     = 4,
  parameter int GAP_W       = 2,
  parameter int SYNC_STAGES = 2
) (
  input logic   clk,
  input logic   rst_n,
  inta_if.master bus
);

  localparam int MAXW = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW   = $clog2(MAXW + 1);

  localparam logic [CW-1:0] P_LD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] G_LD = CW'(GAP_W - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PULSE1,
    GAP,
    PULSE2,
    PRESENT,
    RECOVER
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic                   int_sync;
  logic                   cnt_done;
  logic                   capture;

  logic       inta_n_q;
  logic       hold_q;
  logic       valid_q;
  logic [7:0] vec_q;

  assign int_sync = sync[SYNC_STAGES-1];
  assign cnt_done = (cnt == '0);

  // INT is asynchronous to clk: plain shift-register synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.INT};
    end
  end

  // State and phase counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state; counter reloads on every state entry
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    if (!cnt_done) begin
      cnt_nx = cnt - ONE;
    end
    unique case (state)
      IDLE: begin
        if (int_sync && bus.int_enable) begin
          state_nx = PULSE1;
          cnt_nx   = P_LD;
        end
      end
      PULSE1: begin
        if (cnt_done) begin
          state_nx = GAP;
          cnt_nx   = G_LD;
        end
      end
      GAP: begin
        if (cnt_done) begin
          state_nx = PULSE2;
          cnt_nx   = P_LD;
        end
      end
      PULSE2: begin
        if (cnt_done) begin
          state_nx = PRESENT;
          cnt_nx   = '0;
          capture  = 1'b1;
        end
      end
      PRESENT: begin
        if (bus.vec_ready) begin
          state_nx = RECOVER;
          cnt_nx   = G_LD;
        end
      end
      RECOVER: begin
        if (cnt_done) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Strobes are registered from the next state so they change on the
  // same edge as the state; the vector is latched as pulse 2 ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inta_n_q <= 1'b1;
      hold_q   <= 1'b0;
      valid_q  <= 1'b0;
      vec_q    <= 8'h00;
    end else begin
      inta_n_q <= !((state_nx == PULSE1) || (state_nx == PULSE2));
      hold_q   <= (state_nx == PULSE1) || (state_nx == GAP) ||
                  (state_nx == PULSE2);
      valid_q  <= (state_nx == PRESENT);
      if (capture) begin
        vec_q <= bus.D_in;
      end
    end
  end

  assign bus.INTA_n    = inta_n_q;
  assign bus.bus_hold  = hold_q;
  assign bus.vec_valid = valid_q;
  assign bus.vec_data  = vec_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_inta_cycle_sequencer.sv
// Bench for inta_cycle_sequencer: vector table of full acknowledge
// cycles plus hand-written enable, reset and back-to-back sequences.
module tb_inta_cycle_sequencer;

  localparam int PW = 4;
  localparam int GW = 2;
  localparam int SS = 2;

  logic clk;
  logic rst_n;

  inta_if bus ();

  inta_cycle_sequencer #(
    .PULSE_W    (PW),
    .GAP_W      (GW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;

  typedef struct {
    logic [7:0] d;
    logic [7:0] exp_vec;
    int         rw;
    bit         drop_gap;
    int         exp_lat;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard: every vec_valid rise consumes one expected vector
  always @(negedge clk) begin
    if (bus.vec_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: vec_data=%0h, required no vector",
                 bus.vec_data);
      end else begin
        chk("sb_vec", {24'h0, bus.vec_data}, {24'h0, exp_q.pop_front()});
      end
    end
    prev_valid <= bus.vec_valid;
  end

  task automatic wait_fall(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (bus.INTA_n === 1'b0) begin
        lat = i;
        break;
      end
    end
  endtask

  // Entered at the negedge of cycle 0 (first cycle of INTA_n low)
  task automatic ack_cycle(input logic [7:0] d, input logic [7:0] ev,
                           input int rw, input bit drop_gap,
                           input bit drop_pres, input bit tie,
                           input int abort_c);
    bit lo;
    for (int c = 0; c < 2*PW+GW; c++) begin
      lo = (c < PW) || (c >= PW+GW);
      chk("inta_n", {31'h0, bus.INTA_n}, {31'h0, !lo});
      chk("bus_hold", {31'h0, bus.bus_hold}, 1);
      chk("busy", {31'h0, bus.busy}, 1);
      chk("valid_low", {31'h0, bus.vec_valid}, 0);
      if (c == abort_c) begin
        rst_n = 1'b0;
        #1;
        chk("rst_inta_n", {31'h0, bus.INTA_n}, 1);
        chk("rst_hold", {31'h0, bus.bus_hold}, 0);
        chk("rst_valid", {31'h0, bus.vec_valid}, 0);
        chk("rst_busy", {31'h0, bus.busy}, 0);
        return;
      end
      if (drop_gap && c == PW) bus.INT = 1'b0;
      bus.D_in = (c >= PW+GW) ? d : ((c < PW) ? ~d : 8'h5A);
      if (c == 2*PW+GW-1) exp_q.push_back(ev);
      tick();
    end
    chk("valid_high", {31'h0, bus.vec_valid}, 1);
    chk("present_inta", {31'h0, bus.INTA_n}, 1);
    chk("present_hold", {31'h0, bus.bus_hold}, 0);
    chk("vec_data", {24'h0, bus.vec_data}, {24'h0, ev});
    if (drop_pres) bus.INT = 1'b0;
    bus.D_in = ~d;
    for (int w = 0; w < rw; w++) begin
      tick();
      chk("valid_hold", {31'h0, bus.vec_valid}, 1);
      chk("data_hold", {24'h0, bus.vec_data}, {24'h0, ev});
    end
    bus.vec_ready = 1'b1;
    tick();
    if (!tie) bus.vec_ready = 1'b0;
    chk("valid_clear", {31'h0, bus.vec_valid}, 0);
    chk("recover1", {31'h0, bus.busy}, 1);
    tick();
    chk("recover2", {31'h0, bus.busy}, 1);
    chk("recover_inta", {31'h0, bus.INTA_n}, 1);
    tick();
    chk("idle_busy", {31'h0, bus.busy}, 0);
    chk("idle_inta", {31'h0, bus.INTA_n}, 1);
  endtask

  initial begin
    int lat;
    tbl[0] = '{d: 8'h4B, exp_vec: 8'h4B, rw: 0,  drop_gap: 0, exp_lat: 3};
    tbl[1] = '{d: 8'hFF, exp_vec: 8'hFF, rw: 2,  drop_gap: 1, exp_lat: 3};
    tbl[2] = '{d: 8'hA5, exp_vec: 8'hA5, rw: 15, drop_gap: 0, exp_lat: 3};
    tbl[3] = '{d: 8'h3C, exp_vec: 8'h3C, rw: 1,  drop_gap: 0, exp_lat: 3};

    rst_n          = 1'b0;
    bus.INT        = 1'b0;
    bus.int_enable = 1'b0;
    bus.D_in       = 8'h00;
    bus.vec_ready  = 1'b0;
    repeat (2) tick();
    chk("reset_inta", {31'h0, bus.INTA_n}, 1);
    chk("reset_hold", {31'h0, bus.bus_hold}, 0);
    chk("reset_valid", {31'h0, bus.vec_valid}, 0);
    chk("reset_data", {24'h0, bus.vec_data}, 0);
    chk("reset_busy", {31'h0, bus.busy}, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 4; i++) begin
      bus.INT        = 1'b1;
      bus.int_enable = 1'b1;
      wait_fall(8, lat);
      chk("latency", lat, tbl[i].exp_lat);
      ack_cycle(tbl[i].d, tbl[i].exp_vec, tbl[i].rw, tbl[i].drop_gap,
                1'b1, 1'b0, -1);
      for (int k = 0; k < 4; k++) begin
        tick();
        chk("no_retrigger", {31'h0, bus.INTA_n}, 1);
      end
    end

    bus.INT        = 1'b1;
    bus.int_enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("en_off_inta", {31'h0, bus.INTA_n}, 1);
      chk("en_off_busy", {31'h0, bus.busy}, 0);
    end
    bus.int_enable = 1'b1;
    wait_fall(1, lat);
    chk("en_latency", lat, 1);
    ack_cycle(8'h5C, 8'h5C, 0, 1'b0, 1'b1, 1'b0, -1);
    repeat (3) tick();

    bus.INT = 1'b1;
    wait_fall(8, lat);
    chk("pre_rst_latency", lat, 3);
    ack_cycle(8'hE1, 8'hE1, 0, 1'b0, 1'b0, 1'b0, PW+GW+1);
    tick();
    chk("in_rst_inta", {31'h0, bus.INTA_n}, 1);
    tick();
    rst_n = 1'b1;
    wait_fall(6, lat);
    chk("post_rst_latency", lat, SS+1);
    ack_cycle(8'h77, 8'h77, 0, 1'b0, 1'b1, 1'b0, -1);
    repeat (3) tick();

    bus.INT       = 1'b1;
    bus.vec_ready = 1'b1;
    wait_fall(8, lat);
    chk("b2b_latency", lat, 3);
    ack_cycle(8'h96, 8'h96, 0, 1'b0, 1'b0, 1'b1, -1);
    wait_fall(1, lat);
    chk("b2b_gap", lat, 1);
    ack_cycle(8'h69, 8'h69, 0, 1'b0, 1'b1, 1'b1, -1);
    bus.vec_ready = 1'b0;
    repeat (3) tick();

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
